id_branch_ctrl: RTL and testbench
=================================

// Module: id_branch_ctrl
// PURPOSE
//  Decode-side partner of the fetch stage: consumes the fetched instr each cycle,
//  decodes RV32I fields into a registered ID/EX bundle, and drives the redirect
//  pair (s, pc_imm) back into the fetch PC mux.
//  Keeps a shadow PC that mirrors the fetch PC, so branch and jump targets are
//  computed locally. Also handles illegal-opcode traps and ECALL/EBREAK halts.
// PARAMETERS
//  n            32      datapath / PC width
//  TRAP_VEC     32'h100 redirect target on an illegal instruction
//  HALT_ON_TRAP 1       1: illegal instr -> HALT after the trap redirect; 0: keep running
//  CNT_W        16      width of taken-redirect counter
// PORTS
//  clk       in   1   clock, rising edge
//  reset     in   1   asynchronous, active-low reset
//  instr     in   n   instruction fetched at the current PC (combinational from fetch)
//  rs1_data  in   n   register-file read data for instr[19:15]
//  rs2_data  in   n   register-file read data for instr[24:20]
//  s         out  1   1 = fetch must load pc_imm next edge; 0 = load pc+4
//  pc_imm    out  n   redirect target (valid when s=1)
//  pc        out  n   shadow PC: address of the current instr
//  valid_d   out  1   registered: ID/EX bundle is valid
//  rd_d      out  5   registered rd field
//  rs1_d     out  5   registered rs1 field
//  rs2_d     out  5   registered rs2 field
//  imm_d     out  n   registered sign-extended immediate (I/S/B/U/J by opcode)
//  op_d      out  4   registered class: 0 ALU-R, 1 ALU-I, 2 LOAD, 3 STORE, 4 BR, 5 JAL,
//                     6 JALR, 7 LUI, 8 AUIPC, 9 SYS
//  trap      out  1   combinational pulse: current instr is illegal (RUN only)
//  halted    out  1   1 while the FSM is in HALT
//  br_cnt    out  CNT_W  count of redirects (taken branch/jump/trap); saturating
// BEHAVIOUR
//  Reset (reset=0, async): pc=0, state=RUN, valid_d=0, rd_d/rs1_d/rs2_d/imm_d/op_d=0,
//    br_cnt=0. s, pc_imm and trap follow from the reset state: s=0, trap=0.
//  Shadow PC: each edge, pc <= s ? pc_imm : pc+4, modulo 2^n. It wraps silently.
//  FSM states: RUN, HALT.
//  RUN, combinational decode of instr:
//   - JAL: s=1, pc_imm=pc+immJ.
//   - JALR: s=1, pc_imm=(rs1_data+immI) & ~1.
//   - BRANCH (funct3 BEQ/BNE/BLT/BGE/BLTU/BGEU): s=1 iff the condition holds,
//     pc_imm=pc+immB. BLT/BGE compare signed; BLTU/BGEU compare unsigned.
//     funct3 010 or 011 is illegal.
//   - SYSTEM with ECALL/EBREAK: s=1, pc_imm=pc. Next state is HALT.
//   - Unknown opcode: trap=1, s=1, pc_imm=TRAP_VEC. Next state is HALT if
//     HALT_ON_TRAP=1, otherwise RUN.
//   - All other legal ops: s=0.
//  HALT: s=1, pc_imm=pc (fetch spins on itself), trap=0, valid_d<=0.
//    Only reset exits HALT.
//  ID/EX register, latency 1: on each edge in RUN, the fields of the current instr
//    are captured. valid_d<=1 for legal instrs and 0 for trapping ones.
//  br_cnt: +1 on each RUN edge with s=1. It holds at 2^CNT_W-1 and does not wrap.
//  There is no wrong-path instruction: fetch is combinational from pc, so no flush
//    is needed.
//  Reset asserted mid-cycle clears all state immediately. The redirect in flight is
//    lost and fetch restarts at 0.
// TESTING
//  1. Reset, then instr=ADDI x1,x0,5 -> pc 0,4,8; s=0; next cycle valid_d=1,
//     op_d=1, rd_d=1, imm_d=5.
//  2. At pc=8, BEQ with imm=-8 and rs1_data==rs2_data=7 -> s=1, pc_imm=0, next pc=0,
//     br_cnt=1. With rs2_data=6 -> s=0, next pc=12.
//  3. At pc=4, BLT rs1=32'hFFFF_FFFF, rs2=1, imm=16 -> taken, pc_imm=20.
//     BLTU with the same operands -> not taken.
//  4. At pc=12, JALR rs1_data=32'h203, imm=4 -> pc_imm=32'h206.
//  5. instr=32'h0000_007F -> trap=1, pc_imm=32'h100, valid_d=0. Next cycle
//     halted=1, s=1, pc_imm=pc=32'h100. Holds until reset=0.
//  6. Force br_cnt to 16'hFFFE, take 3 branches -> br_cnt stays 16'hFFFF.
//     Assert reset mid-branch -> pc=0, br_cnt=0 asynchronously.

Source files
------------

// File: rtl/id_branch_ctrl.sv
// id_branch_ctrl: decode stage paired with a combinational fetch.
// The block keeps a shadow copy of the fetch PC. It decodes RV32I fields into a
// registered ID/EX bundle and computes the redirect (s, pc_imm) that the fetch
// PC mux consumes. An illegal instruction redirects to TRAP_VEC. ECALL and
// EBREAK park the core in HALT, where fetch spins on the current PC until reset.
module id_branch_ctrl #(
    parameter int            n            = 32,
    parameter logic [n-1:0]  TRAP_VEC     = 32'h100,
    parameter bit            HALT_ON_TRAP = 1'b1,
    parameter int            CNT_W        = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [n-1:0]     instr,
    input  logic [n-1:0]     rs1_data,
    input  logic [n-1:0]     rs2_data,
    output logic             s,
    output logic [n-1:0]     pc_imm,
    output logic [n-1:0]     pc,
    output logic             valid_d,
    output logic [4:0]       rd_d,
    output logic [4:0]       rs1_d,
    output logic [4:0]       rs2_d,
    output logic [n-1:0]     imm_d,
    output logic [3:0]       op_d,
    output logic             trap,
    output logic             halted,
    output logic [CNT_W-1:0] br_cnt
);

    // FSM encoding
    localparam logic ST_RUN  = 1'b0;
    localparam logic ST_HALT = 1'b1;

    // RV32I major opcodes
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

    // Instruction classes carried in op_d
    localparam logic [3:0] CL_ALU_R = 4'd0;
    localparam logic [3:0] CL_ALU_I = 4'd1;
    localparam logic [3:0] CL_LOAD  = 4'd2;
    localparam logic [3:0] CL_STORE = 4'd3;
    localparam logic [3:0] CL_BR    = 4'd4;
    localparam logic [3:0] CL_JAL   = 4'd5;
    localparam logic [3:0] CL_JALR  = 4'd6;
    localparam logic [3:0] CL_LUI   = 4'd7;
    localparam logic [3:0] CL_AUIPC = 4'd8;
    localparam logic [3:0] CL_SYS   = 4'd9;

    localparam logic [n-1:0]     PC_STEP = n'(4);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic         state;
    logic         next_state;

    logic [6:0]   opcode;
    logic [2:0]   funct3;
    logic [n-1:0] imm_i;
    logic [n-1:0] imm_s;
    logic [n-1:0] imm_b;
    logic [n-1:0] imm_u;
    logic [n-1:0] imm_j;
    logic [n-1:0] jalr_sum;

    logic         legal;
    logic         br_taken;
    logic         is_env;
    logic [3:0]   dec_op;
    logic [n-1:0] dec_imm;

    assign opcode = instr[6:0];
    assign funct3 = instr[14:12];

    // Sign-extended immediates for every format; the class picks one below.
    assign imm_i = {{(n-12){instr[31]}}, instr[31:20]};
    assign imm_s = {{(n-12){instr[31]}}, instr[31:25], instr[11:7]};
    assign imm_b = {{(n-13){instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
    assign imm_u = {{(n-32){instr[31]}}, instr[31:12], 12'b0};
    assign imm_j = {{(n-21){instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};

    assign jalr_sum = rs1_data + imm_i;
    assign halted   = (state == ST_HALT);

    // ECALL (imm 0) and EBREAK (imm 1): funct3 000 with rs1 = rd = 0
    assign is_env = (funct3 == 3'b000) && (instr[31:21] == 11'd0) && (instr[19:7] == 13'd0);

    // Branch condition evaluation; the funct3 values 010/011 are screened out as illegal.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        br_taken = 1'b0;
        case (funct3)
            3'b000:  br_taken = (rs1_data == rs2_data);
            3'b001:  br_taken = (rs1_data != rs2_data);
            3'b100:  br_taken = ($signed(rs1_data) <  $signed(rs2_data));
            3'b101:  br_taken = ($signed(rs1_data) >= $signed(rs2_data));
            3'b110:  br_taken = (rs1_data <  rs2_data);
            3'b111:  br_taken = (rs1_data >= rs2_data);
            default: br_taken = 1'b0;
        endcase
    end

    // Decode: instruction class, immediate, legality and the redirect request.
    always_comb begin
        legal      = 1'b1;
        dec_op     = CL_ALU_R;
        dec_imm    = '0;
        s          = 1'b0;
        pc_imm     = pc;
        trap       = 1'b0;
        next_state = state;

        case (opcode)
            OPC_OP: begin
                dec_op = CL_ALU_R;
            end
            OPC_OP_IMM: begin
                dec_op  = CL_ALU_I;
                dec_imm = imm_i;
            end
            OPC_LOAD: begin
                dec_op  = CL_LOAD;
                dec_imm = imm_i;
            end
            OPC_STORE: begin
                dec_op  = CL_STORE;
                dec_imm = imm_s;
            end
            OPC_BRANCH: begin
                dec_op  = CL_BR;
                dec_imm = imm_b;
                legal   = (funct3 != 3'b010) && (funct3 != 3'b011);
                s       = br_taken;
                pc_imm  = pc + imm_b;
            end
            OPC_JAL: begin
                dec_op  = CL_JAL;
                dec_imm = imm_j;
                s       = 1'b1;
                pc_imm  = pc + imm_j;
            end
            OPC_JALR: begin
                dec_op  = CL_JALR;
                dec_imm = imm_i;
                s       = 1'b1;
                pc_imm  = {jalr_sum[n-1:1], 1'b0};
            end
            OPC_LUI: begin
                dec_op  = CL_LUI;
                dec_imm = imm_u;
            end
            OPC_AUIPC: begin
                dec_op  = CL_AUIPC;
                dec_imm = imm_u;
            end
            OPC_SYSTEM: begin
                dec_op  = CL_SYS;
                dec_imm = imm_i;
                if (is_env) begin
                    s          = 1'b1;
                    pc_imm     = pc;
                    next_state = ST_HALT;
                end
            end
            default: begin
                legal = 1'b0;
            end
        endcase

        // Illegal instructions override whatever the class decode asked for.
        if (!legal) begin
            s          = 1'b1;
            pc_imm     = TRAP_VEC;
            trap       = 1'b1;
            next_state = HALT_ON_TRAP ? ST_HALT : ST_RUN;
        end

        // HALT: fetch spins on the current PC and nothing is decoded.
        if (state == ST_HALT) begin
            s          = 1'b1;
            pc_imm     = pc;
            trap       = 1'b0;
            next_state = ST_HALT;
        end
    end

    // Run/halt state; only reset leaves HALT.
    always_ff @(posedge clk or negedge reset) begin
        // NOTE: sequential state uses non-blocking assignments and an asynchronous active-low reset.
        if (!reset) state <= ST_RUN;
        else        state <= next_state;
    end

    // Shadow PC that mirrors the fetch PC mux and wraps silently.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) pc <= '0;
        else        pc <= s ? pc_imm : pc + PC_STEP;
    end

    // ID/EX register: capture the decoded fields in RUN; drop validity in HALT.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            valid_d <= 1'b0;
            rd_d    <= '0;
            rs1_d   <= '0;
            rs2_d   <= '0;
            imm_d   <= '0;
            op_d    <= '0;
        end else if (state == ST_RUN) begin
            valid_d <= legal;
            rd_d    <= instr[11:7];
            rs1_d   <= instr[19:15];
            rs2_d   <= instr[24:20];
            imm_d   <= dec_imm;
            op_d    <= dec_op;
        end else begin
            valid_d <= 1'b0;
        end
    end

    // Saturating count of redirects taken while running.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            br_cnt <= '0;
        else if ((state == ST_RUN) && s && (br_cnt != CNT_MAX))
            br_cnt <= br_cnt + 1'b1;
    end

endmodule

// File: tb/tb_id_branch_ctrl.sv
// Directed testbench for id_branch_ctrl. A second instance with a 2-bit
// counter is fed a JAL every cycle to reach counter saturation quickly.
module tb_id_branch_ctrl;

    localparam logic [31:0] I_ADDI  = 32'h0050_0093; // addi x1,x0,5
    localparam logic [31:0] I_BEQ   = 32'hFE20_8CE3; // beq  x1,x2,-8
    localparam logic [31:0] I_BLT   = 32'h0020_C863; // blt  x1,x2,16
    localparam logic [31:0] I_BLTU  = 32'h0020_E863; // bltu x1,x2,16
    localparam logic [31:0] I_JALR  = 32'h0040_8067; // jalr x0,4(x1)
    localparam logic [31:0] I_JAL   = 32'h0080_00EF; // jal  x1,8
    localparam logic [31:0] I_ECALL = 32'h0000_0073; // ecall
    localparam logic [31:0] I_ILL   = 32'h0000_007F; // unknown opcode

    logic        clk;
    logic        reset;
    logic [31:0] instr, rs1_data, rs2_data;

    logic        s, valid_d, trap, halted;
    logic [31:0] pc_imm, pc, imm_d;
    logic [4:0]  rd_d, rs1_d, rs2_d;
    logic [3:0]  op_d;
    logic [15:0] br_cnt;

    logic [31:0] sat_instr;
    logic        sat_s, sat_valid_d, sat_trap, sat_halted;
    logic [31:0] sat_pc_imm, sat_pc, sat_imm_d;
    logic [4:0]  sat_rd_d, sat_rs1_d, sat_rs2_d;
    logic [3:0]  sat_op_d;
    logic [1:0]  sat_br_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    id_branch_ctrl u_dut (
        .clk(clk), .reset(reset), .instr(instr), .rs1_data(rs1_data), .rs2_data(rs2_data),
        .s(s), .pc_imm(pc_imm), .pc(pc), .valid_d(valid_d), .rd_d(rd_d), .rs1_d(rs1_d),
        .rs2_d(rs2_d), .imm_d(imm_d), .op_d(op_d), .trap(trap), .halted(halted), .br_cnt(br_cnt)
    );

    id_branch_ctrl #(.CNT_W(2)) u_sat (
        .clk(clk), .reset(reset), .instr(sat_instr), .rs1_data(rs1_data), .rs2_data(rs2_data),
        .s(sat_s), .pc_imm(sat_pc_imm), .pc(sat_pc), .valid_d(sat_valid_d), .rd_d(sat_rd_d),
        .rs1_d(sat_rs1_d), .rs2_d(sat_rs2_d), .imm_d(sat_imm_d), .op_d(sat_op_d),
        .trap(sat_trap), .halted(sat_halted), .br_cnt(sat_br_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Advance one rising edge and settle 1 time unit past it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset     = 1'b0;
        instr     = I_ADDI;
        rs1_data  = '0;
        rs2_data  = '0;
        sat_instr = I_JAL;

        // Reset state
        #12;
        check("rst_pc",      pc,      32'h0);
        check("rst_s",       {31'b0, s}, 32'h0);
        check("rst_trap",    {31'b0, trap}, 32'h0);
        check("rst_valid",   {31'b0, valid_d}, 32'h0);
        check("rst_halted",  {31'b0, halted}, 32'h0);
        check("rst_br_cnt",  {16'b0, br_cnt}, 32'h0);
        check("rst_op_d",    {28'b0, op_d}, 32'h0);
        reset = 1'b1;
        #1;

        // ADDI x1,x0,5 sequencing through pc 0,4,8
        check("addi_s", {31'b0, s}, 32'h0);
        tick();
        check("addi_pc4",   pc, 32'h4);
        check("addi_valid", {31'b0, valid_d}, 32'h1);
        check("addi_op",    {28'b0, op_d}, 32'h1);
        check("addi_rd",    {27'b0, rd_d}, 32'h1);
        check("addi_imm",   imm_d, 32'h5);
        tick();
        check("addi_pc8",   pc, 32'h8);

        // BEQ at pc=8 with imm -8
        instr = I_BEQ; rs1_data = 32'd7; rs2_data = 32'd6; #1;
        check("beq_nt_s",     {31'b0, s}, 32'h0);
        rs2_data = 32'd7; #1;
        check("beq_t_s",      {31'b0, s}, 32'h1);
        check("beq_t_pcimm",  pc_imm, 32'h0);
        tick();
        check("beq_t_pc",     pc, 32'h0);
        check("beq_t_cnt",    {16'b0, br_cnt}, 32'h1);
        check("beq_op",       {28'b0, op_d}, 32'h4);
        check("beq_imm",      imm_d, 32'hFFFF_FFF8);
        check("beq_rs1_d",    {27'b0, rs1_d}, 32'h1);
        check("beq_rs2_d",    {27'b0, rs2_d}, 32'h2);
        instr = I_ADDI;
        tick();
        check("pc_after_addi", pc, 32'h4);

        // BLT / BLTU at pc=4 with rs1=-1, rs2=1
        instr = I_BLT; rs1_data = 32'hFFFF_FFFF; rs2_data = 32'd1; #1;
        check("blt_s",     {31'b0, s}, 32'h1);
        check("blt_pcimm", pc_imm, 32'd20);
        instr = I_BLTU; #1;
        check("bltu_s",    {31'b0, s}, 32'h0);
        tick();
        check("bltu_pc",   pc, 32'h8);
        check("bltu_cnt",  {16'b0, br_cnt}, 32'h1);
        check("bltu_imm",  imm_d, 32'd16);

        // BEQ not taken at pc=8 falls through to 12
        instr = I_BEQ; rs1_data = 32'd7; rs2_data = 32'd6;
        tick();
        check("beq_nt_pc", pc, 32'd12);

        // JALR at pc=12
        instr = I_JALR; rs1_data = 32'h203; #1;
        check("jalr_s",     {31'b0, s}, 32'h1);
        check("jalr_pcimm", pc_imm, 32'h206);
        tick();
        check("jalr_pc",    pc, 32'h206);
        check("jalr_cnt",   {16'b0, br_cnt}, 32'h2);
        check("jalr_op",    {28'b0, op_d}, 32'h6);
        check("jalr_imm",   imm_d, 32'h4);

        // JAL +8 at pc=0x206
        instr = I_JAL; #1;
        check("jal_pcimm", pc_imm, 32'h20E);
        tick();
        check("jal_pc",    pc, 32'h20E);
        check("jal_op",    {28'b0, op_d}, 32'h5);
        check("jal_rd",    {27'b0, rd_d}, 32'h1);
        check("jal_cnt",   {16'b0, br_cnt}, 32'h3);

        // Illegal opcode: trap, redirect to 0x100, then HALT
        instr = I_ILL; #1;
        check("ill_trap",  {31'b0, trap}, 32'h1);
        check("ill_s",     {31'b0, s}, 32'h1);
        check("ill_pcimm", pc_imm, 32'h100);
        tick();
        check("ill_valid",  {31'b0, valid_d}, 32'h0);
        check("ill_halted", {31'b0, halted}, 32'h1);
        check("ill_pc",     pc, 32'h100);
        check("ill_cnt",    {16'b0, br_cnt}, 32'h4);
        check("halt_s",     {31'b0, s}, 32'h1);
        check("halt_pcimm", pc_imm, 32'h100);
        check("halt_trap",  {31'b0, trap}, 32'h0);
        instr = I_ADDI;
        tick();
        check("halt_pc_hold",  pc, 32'h100);
        check("halt_valid",    {31'b0, valid_d}, 32'h0);
        check("halt_cnt_hold", {16'b0, br_cnt}, 32'h4);
        check("halt_stays",    {31'b0, halted}, 32'h1);

        // Async reset away from the clock edge leaves HALT immediately
        #2; reset = 1'b0; #1;
        check("areset_pc",     pc, 32'h0);
        check("areset_cnt",    {16'b0, br_cnt}, 32'h0);
        check("areset_halted", {31'b0, halted}, 32'h0);
        #1; reset = 1'b1;

        // ECALL: redirect to itself and halt with a valid SYS bundle
        instr = I_ECALL; #1;
        check("ecall_s",     {31'b0, s}, 32'h1);
        check("ecall_pcimm", pc_imm, 32'h0);
        check("ecall_trap",  {31'b0, trap}, 32'h0);
        tick();
        check("ecall_pc",     pc, 32'h0);
        check("ecall_halted", {31'b0, halted}, 32'h1);
        check("ecall_op",     {28'b0, op_d}, 32'h9);
        check("ecall_valid",  {31'b0, valid_d}, 32'h1);
        check("ecall_cnt",    {16'b0, br_cnt}, 32'h1);

        // Counter saturation on the 2-bit instance (JAL every cycle)
        #2; reset = 1'b0; #1;
        check("sat_rst_cnt", {30'b0, sat_br_cnt}, 32'h0);
        #1; reset = 1'b1;
        instr = I_JAL;
        tick();
        check("sat_cnt1", {30'b0, sat_br_cnt}, 32'h1);
        tick();
        check("sat_cnt2", {30'b0, sat_br_cnt}, 32'h2);
        tick();
        check("sat_cnt3", {30'b0, sat_br_cnt}, 32'h3);
        tick();
        check("sat_hold4", {30'b0, sat_br_cnt}, 32'h3);
        tick();
        check("sat_hold5", {30'b0, sat_br_cnt}, 32'h3);
        check("main_cnt5", {16'b0, br_cnt}, 32'h5);
        check("main_pc5",  pc, 32'd40);

        // Reset asserted in the middle of a taken branch
        #2; reset = 1'b0; #1;
        check("mid_pc",      pc, 32'h0);
        check("mid_cnt",     {16'b0, br_cnt}, 32'h0);
        check("mid_sat_cnt", {30'b0, sat_br_cnt}, 32'h0);
        check("mid_sat_pc",  sat_pc, 32'h0);
        #1; reset = 1'b1;
        tick();
        check("restart_pc", pc, 32'h8);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Watchdog so the run always ends on its own
    initial begin
        #20000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

endmodule
